// File: rtl/mc_accum_processor_if.sv
// Shared memory port of mc_accum_processor: a single req/ready handshake
// carrying instruction fetches, operand reads and STA writes.
// master = processor side, slave = memory side.
interface mc_accum_processor_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mc_accum_processor.sv
// Multi-cycle accumulator processor with one shared memory port that may
// insert wait states. States: FETCH -> DECODE -> (MEM) -> FETCH, plus an
// absorbing HALT.
// Optional feature: define MCP_BUS_TIMEOUT_EN to abort any access that waits
// TIMEOUT cycles; the core then halts with the sticky bus_err flag set.
// Without the macro the core waits forever and bus_err is tied low.
module mc_accum_processor #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  mc_accum_processor_if.master mem,
  output logic                 halted,
  output logic [ADDR_W-1:0]    pc_out,
  output logic [DATA_W-1:0]    acc_out,
  output logic                 bus_err
);

  localparam logic [2:0] OP_LDA  = 3'b000;
  localparam logic [2:0] OP_STA  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_MEM, S_HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] ir;

  logic [2:0]        op;
  logic [ADDR_W-1:0] op_addr;
  logic              access;
  logic              acc_zero;

  assign op       = ir[DATA_W-1 -: 3];
  assign op_addr  = ir[ADDR_W-1:0];
  assign access   = (state == S_FETCH) || (state == S_MEM);
  assign acc_zero = (acc == '0);

  // Accumulator update for the memory-operand instructions (wraps mod 2^DATA_W)
  function automatic logic [DATA_W-1:0] alu(input logic [2:0]        f,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] m);
    case (f)
      OP_ADD:  return a + m;
      OP_SUB:  return a - m;
      default: return m;
    endcase
  endfunction

  // Bus outputs decode from state alone; rst gating drops a pending request at once
  assign mem.mem_req   = access && !rst;
  assign mem.mem_we    = (state == S_MEM) && (op == OP_STA);
  assign mem.mem_addr  = (state == S_MEM) ? op_addr : pc;
  assign mem.mem_wdata = acc;

  assign pc_out  = pc;
  assign acc_out = acc;

`ifdef MCP_BUS_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [WAIT_W-1:0] wait_cnt;
`else
  assign bus_err = 1'b0;
`endif

  // IR bits between opcode and address are don't-care; this sink keeps them
  // (and TIMEOUT in the default build) from reading as dangling
  logic unused_ok;
  assign unused_ok = (^ir) ^ (TIMEOUT != 0);

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_FETCH;
      pc     <= PC_RST;
      acc    <= '0;
      ir     <= '0;
      halted <= 1'b0;
`ifdef MCP_BUS_TIMEOUT_EN
      bus_err  <= 1'b0;
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          if (mem.mem_ready) begin
            ir    <= mem.mem_rdata;
            pc    <= pc + 1'b1;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (op)
            OP_NOT: begin
              acc   <= ~acc;
              state <= S_FETCH;
            end
            OP_JMP: begin
              pc    <= op_addr;
              state <= S_FETCH;
            end
            OP_JZ: begin
              if (acc_zero) pc <= op_addr;
              state <= S_FETCH;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: state <= S_MEM;
          endcase
        end
        S_MEM: begin
          if (mem.mem_ready) begin
            if (op != OP_STA) acc <= alu(op, acc, mem.mem_rdata);
            state <= S_FETCH;
          end
        end
        default: state <= S_HALT;
      endcase
`ifdef MCP_BUS_TIMEOUT_EN
      // Count stalled cycles of the current access; abort on the TIMEOUT-th
      if (access && !mem.mem_ready) begin
        if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          wait_cnt <= '0;
          bus_err  <= 1'b1;
          halted   <= 1'b1;
          state    <= S_HALT;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
`endif
    end
  end

endmodule
